// File: rtl/iob_axi2iob_burst.sv
`timescale 1ns/1ps
// AXI4 slave to IOb native master bridge. AXI bursts are serialised into single-word
// IOb accesses. One transaction is in flight at a time, and write/read are granted round-robin.
module iob_axi2iob_burst #(
   parameter int AXI_ID_W  = 1,
   parameter int AXI_LEN_W = 8,
   parameter int ADDR_W    = 32,
   parameter int DATA_W    = 32
) (
   input  logic                  clk_i,
   input  logic                  arst_i,
   input  logic                  cke_i,
   // AW channel
   input  logic                  axi_awvalid_i,
   output logic                  axi_awready_o,
   input  logic [ADDR_W-1:0]     axi_awaddr_i,
   input  logic [AXI_ID_W-1:0]   axi_awid_i,
   input  logic [AXI_LEN_W-1:0]  axi_awlen_i,
   input  logic [2:0]            axi_awsize_i,
   input  logic [1:0]            axi_awburst_i,
   // W channel
   input  logic                  axi_wvalid_i,
   output logic                  axi_wready_o,
   input  logic [DATA_W-1:0]     axi_wdata_i,
   input  logic [DATA_W/8-1:0]   axi_wstrb_i,
   input  logic                  axi_wlast_i,
   // B channel
   output logic                  axi_bvalid_o,
   input  logic                  axi_bready_i,
   output logic [AXI_ID_W-1:0]   axi_bid_o,
   output logic [1:0]            axi_bresp_o,
   // AR channel
   input  logic                  axi_arvalid_i,
   output logic                  axi_arready_o,
   input  logic [ADDR_W-1:0]     axi_araddr_i,
   input  logic [AXI_ID_W-1:0]   axi_arid_i,
   input  logic [AXI_LEN_W-1:0]  axi_arlen_i,
   input  logic [2:0]            axi_arsize_i,
   input  logic [1:0]            axi_arburst_i,
   // R channel
   output logic                  axi_rvalid_o,
   input  logic                  axi_rready_i,
   output logic [DATA_W-1:0]     axi_rdata_o,
   output logic [AXI_ID_W-1:0]   axi_rid_o,
   output logic [1:0]            axi_rresp_o,
   output logic                  axi_rlast_o,
   // IOb native master
   output logic                  iob_avalid_o,
   output logic [ADDR_W-1:0]     iob_addr_o,
   output logic [DATA_W-1:0]     iob_wdata_o,
   output logic [DATA_W/8-1:0]   iob_wstrb_o,
   input  logic                  iob_ready_i,
   input  logic                  iob_rvalid_i,
   input  logic [DATA_W-1:0]     iob_rdata_i
);

   localparam int STRB_W = DATA_W / 8;

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_WRITE = 3'd1;
   localparam logic [2:0] S_WRESP = 3'd2;
   localparam logic [2:0] S_RREQ  = 3'd3;
   localparam logic [2:0] S_RWAIT = 3'd4;
   localparam logic [2:0] S_RRESP = 3'd5;

   localparam logic [AXI_LEN_W-1:0] LEN_ONE = AXI_LEN_W'(1);

   logic [2:0]           r_state;
   logic                 r_last_rd;
   logic [ADDR_W-1:0]    r_addr;
   logic [AXI_ID_W-1:0]  r_id;
   logic [AXI_LEN_W-1:0] r_len;
   logic [AXI_LEN_W-1:0] r_cnt;
   logic [2:0]           r_size;
   logic [1:0]           r_burst;
   logic                 r_err;
   logic [DATA_W-1:0]    r_rdata;

   logic                 w_idle;
   logic                 w_write;
   logic                 w_wstrb_nz;
   logic                 w_last_beat;
   logic [ADDR_W-1:0]    w_step;
   logic [ADDR_W-1:0]    w_next_addr;
   logic                 w_awready;
   logic                 w_arready;
   logic                 w_wready;
   logic                 w_wbeat;

   assign w_idle      = (r_state == S_IDLE);
   assign w_write     = (r_state == S_WRITE);
   assign w_wstrb_nz  = |axi_wstrb_i;
   assign w_last_beat = (r_cnt == r_len);

   // FIXED holds the address; INCR and WRAP both step by the beat size
   assign w_step      = ADDR_W'(1) << r_size;
   assign w_next_addr = (r_burst == 2'b00) ? r_addr : r_addr + w_step;

   // last_rd=1 favours write on contention, so grants alternate
   assign w_awready = cke_i & w_idle & axi_awvalid_i & (~axi_arvalid_i | r_last_rd);
   assign w_arready = cke_i & w_idle & axi_arvalid_i & (~axi_awvalid_i | ~r_last_rd);

   // an all-zero-strobe beat is swallowed without touching IOb
   assign w_wready = cke_i & w_write & (w_wstrb_nz ? iob_ready_i : 1'b1);
   assign w_wbeat  = w_wready & axi_wvalid_i;

   assign axi_awready_o = w_awready;
   assign axi_arready_o = w_arready;
   assign axi_wready_o  = w_wready;

   assign axi_bvalid_o = (r_state == S_WRESP);
   assign axi_bid_o    = r_id;
   assign axi_bresp_o  = ((r_state == S_WRESP) && r_err) ? 2'b10 : 2'b00;

   assign axi_rvalid_o = (r_state == S_RRESP);
   assign axi_rdata_o  = r_rdata;
   assign axi_rid_o    = r_id;
   assign axi_rresp_o  = 2'b00;
   assign axi_rlast_o  = (r_state == S_RRESP) && w_last_beat;

   assign iob_avalid_o = cke_i & ((w_write & axi_wvalid_i & w_wstrb_nz) | (r_state == S_RREQ));
   assign iob_addr_o   = r_addr;
   assign iob_wdata_o  = w_write ? axi_wdata_i : '0;
   assign iob_wstrb_o  = w_write ? axi_wstrb_i : {STRB_W{1'b0}};

   always_ff @(posedge clk_i or posedge arst_i) begin
      if (arst_i) begin
         r_state   <= S_IDLE;
         r_last_rd <= 1'b1;
         r_addr    <= '0;
         r_id      <= '0;
         r_len     <= '0;
         r_cnt     <= '0;
         r_size    <= '0;
         r_burst   <= '0;
         r_err     <= 1'b0;
         r_rdata   <= '0;
      end else if (cke_i) begin
         unique case (r_state)
            S_IDLE: begin
               if (w_awready) begin
                  r_addr    <= axi_awaddr_i;
                  r_id      <= axi_awid_i;
                  r_len     <= axi_awlen_i;
                  r_size    <= axi_awsize_i;
                  r_burst   <= axi_awburst_i;
                  r_cnt     <= '0;
                  r_last_rd <= 1'b0;
                  r_state   <= S_WRITE;
               end else if (w_arready) begin
                  r_addr    <= axi_araddr_i;
                  r_id      <= axi_arid_i;
                  r_len     <= axi_arlen_i;
                  r_size    <= axi_arsize_i;
                  r_burst   <= axi_arburst_i;
                  r_cnt     <= '0;
                  r_last_rd <= 1'b1;
                  r_state   <= S_RREQ;
               end
            end
            S_WRITE: begin
               if (w_wbeat) begin
                  // wlast must coincide exactly with the final counted beat
                  if (axi_wlast_i != w_last_beat) r_err <= 1'b1;
                  r_addr <= w_next_addr;
                  r_cnt  <= r_cnt + LEN_ONE;
                  if (w_last_beat) r_state <= S_WRESP;
               end
            end
            S_WRESP: begin
               if (axi_bready_i) begin
                  r_err   <= 1'b0;
                  r_state <= S_IDLE;
               end
            end
            S_RREQ: begin
               if (iob_ready_i) r_state <= S_RWAIT;
            end
            S_RWAIT: begin
               if (iob_rvalid_i) begin
                  r_rdata <= iob_rdata_i;
                  r_state <= S_RRESP;
               end
            end
            S_RRESP: begin
               if (axi_rready_i) begin
                  if (w_last_beat) begin
                     r_state <= S_IDLE;
                  end else begin
                     r_addr  <= w_next_addr;
                     r_cnt   <= r_cnt + LEN_ONE;
                     r_state <= S_RREQ;
                  end
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_iob_axi2iob_burst.sv
`timescale 1ns/1ps
// Directed and randomised bench for iob_axi2iob_burst with an IOb memory slave and
// an address/data reference model derived from the AXI burst rules.
module tb_iob_axi2iob_burst;

   localparam int AXI_ID_W  = 1;
   localparam int AXI_LEN_W = 8;
   localparam int ADDR_W    = 32;
   localparam int DATA_W    = 32;

   logic                 clk_i = 1'b0;
   logic                 arst_i, cke_i;
   logic                 axi_awvalid_i, axi_awready_o;
   logic [ADDR_W-1:0]    axi_awaddr_i;
   logic [AXI_ID_W-1:0]  axi_awid_i;
   logic [AXI_LEN_W-1:0] axi_awlen_i;
   logic [2:0]           axi_awsize_i;
   logic [1:0]           axi_awburst_i;
   logic                 axi_wvalid_i, axi_wready_o;
   logic [DATA_W-1:0]    axi_wdata_i;
   logic [3:0]           axi_wstrb_i;
   logic                 axi_wlast_i;
   logic                 axi_bvalid_o, axi_bready_i;
   logic [AXI_ID_W-1:0]  axi_bid_o;
   logic [1:0]           axi_bresp_o;
   logic                 axi_arvalid_i, axi_arready_o;
   logic [ADDR_W-1:0]    axi_araddr_i;
   logic [AXI_ID_W-1:0]  axi_arid_i;
   logic [AXI_LEN_W-1:0] axi_arlen_i;
   logic [2:0]           axi_arsize_i;
   logic [1:0]           axi_arburst_i;
   logic                 axi_rvalid_o, axi_rready_i;
   logic [DATA_W-1:0]    axi_rdata_o;
   logic [AXI_ID_W-1:0]  axi_rid_o;
   logic [1:0]           axi_rresp_o;
   logic                 axi_rlast_o;
   logic                 iob_avalid_o;
   logic [ADDR_W-1:0]    iob_addr_o;
   logic [DATA_W-1:0]    iob_wdata_o;
   logic [3:0]           iob_wstrb_o;
   logic                 iob_ready_i, iob_rvalid_i;
   logic [DATA_W-1:0]    iob_rdata_i;

   always #5 clk_i = ~clk_i;

   iob_axi2iob_burst #(
      .AXI_ID_W(AXI_ID_W), .AXI_LEN_W(AXI_LEN_W), .ADDR_W(ADDR_W), .DATA_W(DATA_W)
   ) dut (
      .clk_i(clk_i), .arst_i(arst_i), .cke_i(cke_i),
      .axi_awvalid_i(axi_awvalid_i), .axi_awready_o(axi_awready_o), .axi_awaddr_i(axi_awaddr_i),
      .axi_awid_i(axi_awid_i), .axi_awlen_i(axi_awlen_i), .axi_awsize_i(axi_awsize_i),
      .axi_awburst_i(axi_awburst_i),
      .axi_wvalid_i(axi_wvalid_i), .axi_wready_o(axi_wready_o), .axi_wdata_i(axi_wdata_i),
      .axi_wstrb_i(axi_wstrb_i), .axi_wlast_i(axi_wlast_i),
      .axi_bvalid_o(axi_bvalid_o), .axi_bready_i(axi_bready_i), .axi_bid_o(axi_bid_o),
      .axi_bresp_o(axi_bresp_o),
      .axi_arvalid_i(axi_arvalid_i), .axi_arready_o(axi_arready_o), .axi_araddr_i(axi_araddr_i),
      .axi_arid_i(axi_arid_i), .axi_arlen_i(axi_arlen_i), .axi_arsize_i(axi_arsize_i),
      .axi_arburst_i(axi_arburst_i),
      .axi_rvalid_o(axi_rvalid_o), .axi_rready_i(axi_rready_i), .axi_rdata_o(axi_rdata_o),
      .axi_rid_o(axi_rid_o), .axi_rresp_o(axi_rresp_o), .axi_rlast_o(axi_rlast_o),
      .iob_avalid_o(iob_avalid_o), .iob_addr_o(iob_addr_o), .iob_wdata_o(iob_wdata_o),
      .iob_wstrb_o(iob_wstrb_o), .iob_ready_i(iob_ready_i), .iob_rvalid_i(iob_rvalid_i),
      .iob_rdata_i(iob_rdata_i)
   );

   int checks = 0;
   int errors = 0;

   // IOb memory slave state
   logic [31:0] mem [0:1023];
   bit          rdy_rand = 1'b0;
   int          rdy_low  = 0;
   bit          hold_rv  = 1'b0;
   bit          s_pend   = 1'b0;
   logic [31:0] s_pdata;

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [3:0]  strb;
   } acc_t;
   acc_t log_q[$];

   // fields of the transaction currently being exercised
   logic [31:0] t_addr;
   logic [7:0]  t_len;
   logic [2:0]  t_size;
   logic [1:0]  t_burst;
   logic        t_id;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   // address of beat k from the AXI burst rules
   function automatic logic [31:0] beat_addr(input int k);
      logic [31:0] step;
      step = 32'd1 << t_size;
      if (t_burst == 2'b00) return t_addr;
      return t_addr + 32'(k) * step;
   endfunction

   task automatic settle();
      #1;
   endtask

   // record this cycle's IOb handshake, then advance to the next negedge and drive the slave
   task automatic cyc();
      logic [31:0] a;
      if (!arst_i && iob_avalid_o && iob_ready_i) begin
         a = iob_addr_o;
         log_q.push_back('{addr: iob_addr_o, data: iob_wdata_o, strb: iob_wstrb_o});
         if (iob_wstrb_o != 4'h0) begin
            for (int b = 0; b < 4; b++)
               if (iob_wstrb_o[b]) mem[a[11:2]][8*b +: 8] = iob_wdata_o[8*b +: 8];
         end else if (!hold_rv) begin
            s_pend  = 1'b1;
            s_pdata = mem[a[11:2]];
         end
      end
      @(negedge clk_i);
      if (!hold_rv) begin
         iob_rvalid_i = s_pend;
         iob_rdata_i  = s_pend ? s_pdata : $urandom;
         s_pend       = 1'b0;
      end
      if (rdy_low > 0) begin
         iob_ready_i = 1'b0;
         rdy_low--;
      end else begin
         iob_ready_i = rdy_rand ? 1'($urandom_range(0, 1)) : 1'b1;
      end
   endtask

   task automatic do_reset();
      arst_i = 1'b1;
      cke_i = 1'b1;
      axi_awvalid_i = 0; axi_wvalid_i = 0; axi_bready_i = 0; axi_arvalid_i = 0; axi_rready_i = 0;
      axi_wlast_i = 0; axi_wstrb_i = 0; axi_wdata_i = 0;
      iob_rvalid_i = 0; iob_ready_i = 1; iob_rdata_i = 0;
      hold_rv = 0; s_pend = 0; rdy_low = 0;
      @(negedge clk_i);
      @(negedge clk_i);
      arst_i = 1'b0;
   endtask

   task automatic set_txn(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic id);
      t_addr = a; t_len = len; t_size = size; t_burst = burst; t_id = id;
      axi_awaddr_i = a; axi_awlen_i = len; axi_awsize_i = size; axi_awburst_i = burst; axi_awid_i = id;
      axi_araddr_i = a; axi_arlen_i = len; axi_arsize_i = size; axi_arburst_i = burst; axi_arid_i = id;
   endtask

   task automatic aw_phase(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic id);
      int n;
      set_txn(a, len, size, burst, id);
      log_q.delete();
      axi_awvalid_i = 1'b1;
      for (n = 0; n < 50; n++) begin
         settle();
         if (axi_awready_o) break;
         cyc();
      end
      chk("aw_handshake", n < 50, 1);
      cyc();
      axi_awvalid_i = 1'b0;
   endtask

   task automatic ar_phase(input logic [31:0] a, input logic [7:0] len, input logic [2:0] size,
                           input logic [1:0] burst, input logic id);
      int n;
      set_txn(a, len, size, burst, id);
      log_q.delete();
      axi_arvalid_i = 1'b1;
      for (n = 0; n < 50; n++) begin
         settle();
         if (axi_arready_o) break;
         cyc();
      end
      chk("ar_handshake", n < 50, 1);
      cyc();
      axi_arvalid_i = 1'b0;
   endtask

   // W beats plus B response; -1 disables each special beat
   task automatic wb_phase(input int early_last, input int zero_beat, input int stall_beat,
                           input int cke_beat, input bit rnd);
      acc_t        exp_q[$];
      bit          exp_err;
      logic [31:0] data;
      logic [3:0]  strb;
      logic        last;
      int          n;
      exp_err = 1'b0;
      for (int k = 0; k <= int'(t_len); k++) begin
         data = $urandom;
         strb = (k == zero_beat) ? 4'h0 : (rnd ? 4'($urandom_range(0, 15)) : 4'hF);
         last = (early_last >= 0) ? (k == early_last) : (k == int'(t_len));
         if (last != (k == int'(t_len))) exp_err = 1'b1;
         if (strb != 4'h0) exp_q.push_back('{addr: beat_addr(k), data: data, strb: strb});
         if (rnd) begin
            repeat ($urandom_range(0, 1)) begin
               axi_wvalid_i = 1'b0;
               settle();
               cyc();
            end
         end
         axi_wvalid_i = 1'b1; axi_wdata_i = data; axi_wstrb_i = strb; axi_wlast_i = last;
         if (k == stall_beat) begin
            iob_ready_i = 1'b0;
            rdy_low = 1;
         end
         if (k == cke_beat) begin
            cke_i = 1'b0;
            for (int c = 0; c < 5; c++) begin
               settle();
               chk("cke_wready", axi_wready_o, 0);
               chk("cke_avalid", iob_avalid_o, 0);
               chk("cke_addr_hold", iob_addr_o, beat_addr(k));
               cyc();
            end
            cke_i = 1'b1;
         end
         for (n = 0; n < 50; n++) begin
            settle();
            if (k == zero_beat && n == 0) chk("zero_strb_no_avalid", iob_avalid_o, 0);
            if (axi_wready_o) break;
            cyc();
         end
         chk("w_beat_accept", n < 50, 1);
         cyc();
      end
      axi_wvalid_i = 1'b0; axi_wlast_i = 1'b0; axi_wstrb_i = 4'h0;
      settle();
      chk("bvalid_after_last", axi_bvalid_o, 1);
      if (rnd) begin
         repeat ($urandom_range(0, 2)) begin
            cyc();
            settle();
            chk("bvalid_hold", axi_bvalid_o, 1);
         end
      end
      axi_bready_i = 1'b1;
      settle();
      chk("bresp", axi_bresp_o, exp_err ? 2'b10 : 2'b00);
      chk("bid", axi_bid_o, t_id);
      cyc();
      axi_bready_i = 1'b0;
      settle();
      chk("bvalid_clear", axi_bvalid_o, 0);
      cyc();
      chk("wr_count", log_q.size(), exp_q.size());
      for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
         chk($sformatf("wr%0d_addr", i), log_q[i].addr, exp_q[i].addr);
         chk($sformatf("wr%0d_data", i), log_q[i].data, exp_q[i].data);
         chk($sformatf("wr%0d_strb", i), log_q[i].strb, exp_q[i].strb);
      end
   endtask

   task automatic r_phase(input bit rnd, output int first_wait);
      logic [31:0] ea;
      logic [31:0] ed;
      int          n;
      first_wait = -1;
      for (int k = 0; k <= int'(t_len); k++) begin
         for (n = 0; n < 50; n++) begin
            settle();
            if (axi_rvalid_o) break;
            cyc();
         end
         if (k == 0) first_wait = n;
         chk("r_beat_valid", n < 50, 1);
         ea = beat_addr(k);
         ed = mem[ea[11:2]];
         if (rnd) begin
            repeat ($urandom_range(0, 2)) begin
               cyc();
               settle();
               chk("rvalid_hold", axi_rvalid_o, 1);
               chk("rdata_hold", axi_rdata_o, ed);
            end
         end
         chk($sformatf("r%0d_data", k), axi_rdata_o, ed);
         chk($sformatf("r%0d_last", k), axi_rlast_o, k == int'(t_len));
         chk("rresp", axi_rresp_o, 2'b00);
         chk("rid", axi_rid_o, t_id);
         axi_rready_i = 1'b1;
         cyc();
         axi_rready_i = 1'b0;
      end
      settle();
      chk("rvalid_clear", axi_rvalid_o, 0);
      cyc();
      chk("rd_count", log_q.size(), int'(t_len) + 1);
      for (int i = 0; i <= int'(t_len) && i < log_q.size(); i++) begin
         chk($sformatf("rd%0d_addr", i), log_q[i].addr, beat_addr(i));
         chk($sformatf("rd%0d_strb", i), log_q[i].strb, 4'h0);
      end
   endtask

   task automatic arb(input int idx, input bit exp_write);
      int fw;
      set_txn(32'h0000_0700 + 32'(idx) * 32'h10, 8'd0, 3'd2, 2'b01, 1'(idx));
      log_q.delete();
      axi_awvalid_i = 1'b1;
      axi_arvalid_i = 1'b1;
      settle();
      chk($sformatf("arb%0d_awready", idx), axi_awready_o, exp_write);
      chk($sformatf("arb%0d_arready", idx), axi_arready_o, !exp_write);
      cyc();
      axi_awvalid_i = 1'b0;
      axi_arvalid_i = 1'b0;
      if (exp_write) wb_phase(-1, -1, -1, -1, 0);
      else r_phase(0, fw);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      int fw;
      int n;
      for (int i = 0; i < 1024; i++) mem[i] = $urandom;
      mem[32'h100 >> 2] = 32'hCAFE_BABE;
      set_txn(32'h0, 8'd0, 3'd2, 2'b01, 1'b0);

      // reset state
      do_reset();
      settle();
      chk("rst_awready", axi_awready_o, 0);
      chk("rst_arready", axi_arready_o, 0);
      chk("rst_wready", axi_wready_o, 0);
      chk("rst_bvalid", axi_bvalid_o, 0);
      chk("rst_rvalid", axi_rvalid_o, 0);
      chk("rst_rlast", axi_rlast_o, 0);
      chk("rst_rdata", axi_rdata_o, 0);
      chk("rst_avalid", iob_avalid_o, 0);
      chk("rst_addr", iob_addr_o, 0);
      chk("rst_wstrb", iob_wstrb_o, 0);
      cyc();

      // arbitration: write, read, write after reset
      arb(0, 1'b1);
      arb(1, 1'b0);
      arb(2, 1'b1);

      // single read and its latency
      ar_phase(32'h100, 8'd0, 3'd2, 2'b01, 1'b1);
      r_phase(0, fw);
      chk("rd_latency", fw, 2);

      // INCR write with IOb stalled two cycles on beat 2
      aw_phase(32'h200, 8'd3, 3'd2, 2'b01, 1'b0);
      wb_phase(-1, -1, 1, -1, 0);

      // early wlast on beat 2 of 4
      aw_phase(32'h500, 8'd3, 3'd2, 2'b01, 1'b1);
      wb_phase(1, -1, -1, -1, 0);

      // zero-strobe beat 3 of 4
      aw_phase(32'h600, 8'd3, 3'd2, 2'b01, 1'b1);
      wb_phase(-1, 2, -1, -1, 0);

      // FIXED read, three beats
      ar_phase(32'h140, 8'd2, 3'd2, 2'b00, 1'b0);
      r_phase(0, fw);

      // clock enable: IDLE readies gated, then a 5-cycle drop during WRITE
      cke_i = 1'b0;
      set_txn(32'h400, 8'd3, 3'd2, 2'b01, 1'b1);
      axi_awvalid_i = 1'b1;
      settle();
      chk("cke_awready", axi_awready_o, 0);
      cyc();
      axi_awvalid_i = 1'b0;
      cke_i = 1'b1;
      aw_phase(32'h400, 8'd3, 3'd2, 2'b01, 1'b1);
      wb_phase(-1, -1, -1, 1, 0);

      // longest burst must not terminate early
      aw_phase(32'h0, 8'd255, 3'd2, 2'b01, 1'b0);
      wb_phase(-1, -1, -1, -1, 0);

      // reset while waiting for the beat-2 read response
      ar_phase(32'h300, 8'd3, 3'd2, 2'b01, 1'b1);
      for (n = 0; n < 50; n++) begin
         settle();
         if (axi_rvalid_o) break;
         cyc();
      end
      chk("mid_rst_beat1", n < 50, 1);
      axi_rready_i = 1'b1;
      cyc();
      axi_rready_i = 1'b0;
      hold_rv = 1'b1;
      settle();
      chk("mid_rst_req", iob_avalid_o, 1);
      cyc();
      settle();
      arst_i = 1'b1;
      settle();
      chk("mid_rst_avalid", iob_avalid_o, 0);
      chk("mid_rst_rvalid", axi_rvalid_o, 0);
      chk("mid_rst_bvalid", axi_bvalid_o, 0);
      chk("mid_rst_rdata", axi_rdata_o, 0);
      chk("mid_rst_addr", iob_addr_o, 0);
      chk("mid_rst_rlast", axi_rlast_o, 0);
      cyc();
      arst_i = 1'b0;
      iob_rvalid_i = 1'b1;
      iob_rdata_i = 32'hDEAD_BEEF;
      settle();
      cyc();
      iob_rvalid_i = 1'b0;
      hold_rv = 1'b0;
      settle();
      chk("late_rvalid_ignored", axi_rvalid_o, 0);
      chk("late_rvalid_avalid", iob_avalid_o, 0);
      cyc();
      ar_phase(32'h300, 8'd1, 3'd2, 2'b01, 1'b0);
      r_phase(0, fw);

      // randomised bursts with random IOb back-pressure
      rdy_rand = 1'b1;
      for (int t = 0; t < 20; t++) begin
         if ($urandom_range(0, 1) == 1) begin
            aw_phase(32'($urandom_range(0, 767)) << 2, 8'($urandom_range(0, 7)),
                     3'($urandom_range(0, 2)), 2'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wb_phase(-1, -1, -1, -1, 1);
         end else begin
            ar_phase(32'($urandom_range(0, 767)) << 2, 8'($urandom_range(0, 7)),
                     3'($urandom_range(0, 2)), 2'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            r_phase(1, fw);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
